pwm_multi_ch: RTL and testbench
===============================

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
- REQ-001 Parameter WIDTH, default 8: bit width of the period counter, period and duty values.
- REQ-002 Parameter CHANNELS, default 4: number of independent PWM outputs sharing one time base; range 1..16.
- REQ-003 Parameter PRESC_W, default 16: bit width of the prescaler counter and divisor.
- REQ-004 clk  input  1  single clock; all state on rising edge.
- REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-006 ena  input  1  count enable; 0 freezes prescaler and period counter.
- REQ-007 presc_i  input  PRESC_W  prescaler divisor; tick every presc_i+1 enabled cycles.
- REQ-008 period_i  input  WIDTH  period length; counter range 0..period_i.
- REQ-009 duty_wr_i  input  1  single-cycle write strobe for a channel's shadow duty register.
- REQ-010 duty_ch_i  input  max(1,clog2(CHANNELS))  target channel index for duty_wr_i.
- REQ-011 duty_i  input  WIDTH  duty value written to the shadow register.
- REQ-012 pwm_o  output  CHANNELS  registered PWM outputs, bit k = channel k.
- REQ-013 period_end_o  output  1  one-cycle pulse, high on the cycle the period counter wraps.

Function
- REQ-014 Prescaler counts 0..presc_i while ena=1; tick is asserted on the cycle it equals presc_i, and it returns to 0 on the next edge.
- REQ-015 presc_i=0 gives tick on every enabled cycle.
- REQ-016 Period counter advances by 1 per tick and wraps from the active period value to 0; period_end_o is high on the cycle tick and wrap coincide.
- REQ-017 period_i is captured into the active period register only at wrap; mid-period changes take effect from the next period.
- REQ-018 duty_wr_i=1 loads duty_i into shadow[duty_ch_i]; writes with duty_ch_i >= CHANNELS are ignored.
- REQ-019 At wrap, every active duty register loads its shadow value; a write in the same cycle as wrap is bypassed, so the newly written value becomes active immediately.
- REQ-020 pwm_o[k] is the registered value of (counter < active_duty[k]), one clock of latency from the counter.
- REQ-021 duty=0 gives constant 0; duty > active period gives constant 1 with no glitch at wrap.
- REQ-022 Comparison is unsigned over WIDTH bits; no arithmetic overflow is permitted (counter never exceeds the active period).
- REQ-023 ena=0 holds counters, pwm_o and period_end_o=0; duty writes are still accepted into the shadow registers.

Reset
- REQ-024 rst_n=0 asynchronously clears the prescaler, period counter, all shadow and active duty registers, pwm_o, and period_end_o to 0.
- REQ-025 The active period register resets to all-ones (2^WIDTH-1).
- REQ-026 After release, the first tick occurs presc_i+1 enabled cycles later; reset mid-period discards the period in progress.

Configuration
- REQ-027 With PWM_CENTER_ALIGNED_EN defined, the period counter counts up 0..period then down period..0 (triangle wave).
  - Period length is 2*period ticks.
  - Wrap, shadow transfer and period_end_o occur when the counter reaches 0 while counting down.
  - pwm_o[k] keeps the rule counter < duty[k].
- REQ-028 Without PWM_CENTER_ALIGNED_EN, the counter is edge-aligned (sawtooth, per REQ-016), and no up/down direction state exists.

Verification
- REQ-029 presc_i=0, period_i=9, duty ch0=3 -> pwm_o[0] high 3 of every 10 cycles; period_end_o once per 10 cycles.
- REQ-030 presc_i=4, period_i=3, duty ch1=2 -> 20-cycle period, pwm_o[1] high for 10 cycles.
- REQ-031 Duty ch2 written 5 -> 7 mid-period, period_i=9 -> current period still 5 high; next period 7 high.
- REQ-032 duty=0 and duty=255 with period_i=254 -> constant 0 and constant 1 across several wraps.
- REQ-033 Duty write coincident with period_end_o -> new value used in the very next period; write to channel index 5 with CHANNELS=4 -> no change.
- REQ-034 rst_n pulsed low mid-period, and ena=0 for 7 cycles -> all outputs 0 asynchronously; during ena=0, pwm_o held and counters frozen.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: CHANNELS PWM outputs on one prescaled time base, with shadowed duty registers.
// Define PWM_CENTER_ALIGNED_EN to use an up/down (triangle) period counter instead of a sawtooth.
module pwm_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             wr,
  input  logic             wrap,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;

  // A write landing on the wrap cycle goes straight into the active register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wr)   shadow <= duty_i;
      if (wrap) active <= wr ? duty_i : shadow;
      if (ena)  pwm    <= (cnt < active);
    end
  end
endmodule

module pwm_multi_ch #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int PRESC_W  = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [PRESC_W-1:0]  presc_i,
  input  logic [WIDTH-1:0]    period_i,
  input  logic                duty_wr_i,
  input  logic [CH_W-1:0]     duty_ch_i,
  input  logic [WIDTH-1:0]    duty_i,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_end_o
);
  typedef struct packed {
    logic             vld;
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] duty;
  } duty_req_t;

  duty_req_t          req;
  logic [PRESC_W-1:0] presc_cnt;
  logic [WIDTH-1:0]   cnt, cnt_nxt, period_act;
  logic               tick, wrap;

  assign req  = '{vld: duty_wr_i, ch: duty_ch_i, duty: duty_i};
  // >= keeps the prescaler bounded if presc_i is lowered below the running count.
  assign tick = ena && (presc_cnt >= presc_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   presc_cnt <= '0;
    else if (ena) presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
  end

`ifdef PWM_CENTER_ALIGNED_EN
  logic dn, dn_nxt;

  // Period 0..P..1 is 2*P ticks; P<=1 wraps straight from the top.
  always_comb begin
    cnt_nxt = cnt;
    dn_nxt  = dn;
    wrap    = 1'b0;
    if (tick) begin
      if (dn ? (cnt <= WIDTH'(1)) : ((cnt >= period_act) && (period_act <= WIDTH'(1)))) begin
        wrap    = 1'b1;
        cnt_nxt = '0;
        dn_nxt  = 1'b0;
      end else if (dn) begin
        cnt_nxt = cnt - WIDTH'(1);
      end else if (cnt >= period_act) begin
        cnt_nxt = cnt - WIDTH'(1);
        dn_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dn <= 1'b0;
    else        dn <= dn_nxt;
  end
`else
  always_comb begin
    wrap    = tick && (cnt >= period_act);
    cnt_nxt = cnt;
    if (wrap)      cnt_nxt = '0;
    else if (tick) cnt_nxt = cnt + WIDTH'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_act <= '1;
    end else begin
      cnt <= cnt_nxt;
      if (wrap) period_act <= period_i;
    end
  end

  assign period_end_o = wrap;

  // Out-of-range channel indices never match a lane, so those writes drop.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_ch #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .wr     (req.vld && (req.ch == CH_W'(k))),
      .wrap   (wrap),
      .duty_i (req.duty),
      .cnt    (cnt),
      .pwm    (pwm_o[k])
    );
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: reference model + scoreboard every cycle, plus windowed duty/period checks.
module tb_pwm_multi_ch;
  localparam int W = 8, NCH = 5, PW = 16, CHW = 3;

  logic           clk, rst_n, ena, duty_wr_i, period_end_o;
  logic [PW-1:0]  presc_i;
  logic [W-1:0]   period_i, duty_i;
  logic [CHW-1:0] duty_ch_i;
  logic [NCH-1:0] pwm_o;

  pwm_multi_ch #(.WIDTH(W), .CHANNELS(NCH), .PRESC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .presc_i(presc_i), .period_i(period_i),
    .duty_wr_i(duty_wr_i), .duty_ch_i(duty_ch_i), .duty_i(duty_i),
    .pwm_o(pwm_o), .period_end_o(period_end_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time base and duty registers as plain numbers.
  int             m_presc;
  logic [W-1:0]   m_cnt, m_per;
  logic [W-1:0]   m_sh [NCH];
  logic [W-1:0]   m_act[NCH];
  logic [NCH-1:0] m_pwm;
  logic           m_tk, m_wrap;

  task automatic m_reset();
    m_presc = 0; m_cnt = '0; m_per = '1; m_pwm = '0;
    for (int k = 0; k < NCH; k++) begin m_sh[k] = '0; m_act[k] = '0; end
  endtask

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else begin
      m_tk   = ena && (m_presc == int'(presc_i));
      m_wrap = m_tk && (m_cnt == m_per);
      if (duty_wr_i && int'(duty_ch_i) < NCH) m_sh[duty_ch_i] = duty_i;
      if (ena) begin
        for (int k = 0; k < NCH; k++) m_pwm[k] = (m_cnt < m_act[k]);
        m_presc = m_tk ? 0 : m_presc + 1;
      end
      if (m_tk) m_cnt = m_wrap ? '0 : m_cnt + 8'd1;
      if (m_wrap) begin
        m_per = period_i;
        for (int k = 0; k < NCH; k++) m_act[k] = m_sh[k];
      end
    end
  end

  typedef struct packed { logic [NCH-1:0] pwm; logic pe; } exp_t;
  exp_t sb_q[$];
  exp_t sb_e, sb_p;

  always @(negedge clk) begin
    if (!rst_n) m_reset();
    sb_p.pwm = m_pwm;
    sb_p.pe  = rst_n && ena && (m_presc == int'(presc_i)) && (m_cnt == m_per);
    sb_q.push_back(sb_p);
  end

  always @(negedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      chk("sb_pwm", 32'(pwm_o), 32'(sb_e.pwm));
      chk("sb_end", 32'(period_end_o), 32'(sb_e.pe));
    end
  end

  task automatic wr_duty(input int ch, input int val);
    @(posedge clk); #1;
    duty_wr_i = 1'b1; duty_ch_i = CHW'(ch); duty_i = W'(val);
    @(posedge clk); #1;
    duty_wr_i = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string nm);
    int n = 0;
    do begin
      @(posedge clk); #1 duty_wr_i = 1'b0;
      @(negedge clk);
      n++;
    end while (!period_end_o && n < budget);
    chk(nm, 32'(period_end_o), 32'd1);
  endtask

  // Counts high cycles per channel and period ends over n cycles; optional write at cycle wr_at.
  task automatic win(input int n, input int wr_at, input int wch, input int wval,
                     output int hi [NCH], output int ends);
    for (int k = 0; k < NCH; k++) hi[k] = 0;
    ends = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      duty_wr_i = (i == wr_at);
      if (i == wr_at) begin duty_ch_i = CHW'(wch); duty_i = W'(wval); end
      @(negedge clk);
      for (int k = 0; k < NCH; k++) hi[k] += int'(pwm_o[k]);
      ends += int'(period_end_o);
    end
  endtask

  int hi [NCH];
  int ends;

  initial begin
    rst_n = 1'b0; ena = 1'b0; presc_i = '0; period_i = '0;
    duty_wr_i = 1'b0; duty_ch_i = '0; duty_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pwm", 32'(pwm_o), 32'd0);
    chk("rst_end", 32'(period_end_o), 32'd0);

    // presc 0, period 9: ch0=3, ch2=5
    @(posedge clk); #1 rst_n = 1'b1; presc_i = '0; period_i = 8'd9; ena = 1'b1;
    wr_duty(0, 3); wr_duty(2, 5);
    wait_end(300, "first_wrap");
    win(10, -1, 0, 0, hi, ends);
    chk("p9_ch0_hi", 32'(hi[0]), 32'd3); chk("p9_ends", 32'(ends), 32'd1);
    chk("p9_ch2_hi", 32'(hi[2]), 32'd5);
    win(10, -1, 0, 0, hi, ends);
    chk("p9_ch0_hi_b", 32'(hi[0]), 32'd3); chk("p9_ends_b", 32'(ends), 32'd1);

    // mid-period shadow update of ch2
    win(10, 3, 2, 7, hi, ends);
    chk("mid_wr_cur", 32'(hi[2]), 32'd5);
    win(10, -1, 0, 0, hi, ends);
    chk("mid_wr_next", 32'(hi[2]), 32'd7);

    // write coincident with wrap, then an out-of-range channel write
    win(10, 9, 0, 6, hi, ends);
    chk("coinc_cur", 32'(hi[0]), 32'd3); chk("coinc_ends", 32'(ends), 32'd1);
    win(10, 4, 5, 9, hi, ends);
    chk("coinc_next", 32'(hi[0]), 32'd6);
    win(10, -1, 0, 0, hi, ends);
    chk("badch_ch0", 32'(hi[0]), 32'd6); chk("badch_ch1", 32'(hi[1]), 32'd0);
    chk("badch_ch3", 32'(hi[3]), 32'd0); chk("badch_ch4", 32'(hi[4]), 32'd0);

    // duty 0 and 255 with period 254
    @(posedge clk); #1 period_i = 8'd254; duty_wr_i = 1'b1; duty_ch_i = 3'd4; duty_i = 8'd255;
    @(posedge clk); #1 duty_ch_i = 3'd3; duty_i = 8'd0;
    @(posedge clk); #1 duty_wr_i = 1'b0;
    wait_end(20, "p254_load");
    wait_end(300, "p254_wrap");
    win(765, -1, 0, 0, hi, ends);
    chk("duty255_hi", 32'(hi[4]), 32'd765); chk("duty0_hi", 32'(hi[3]), 32'd0);
    chk("p254_ends", 32'(ends), 32'd3);

    // presc 4, period 3, ch1=2
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; presc_i = 16'd4; period_i = 8'd3;
    wr_duty(1, 2);
    wait_end(1400, "presc_wrap");
    win(20, -1, 0, 0, hi, ends);
    chk("presc_ch1_hi", 32'(hi[1]), 32'd10); chk("presc_ends", 32'(ends), 32'd1);
    win(20, -1, 0, 0, hi, ends);
    chk("presc_ch1_hi_b", 32'(hi[1]), 32'd10);

    // asynchronous reset mid-period
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("pre_rst_pwm", 32'(pwm_o), 32'd2);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("async_rst_pwm", 32'(pwm_o), 32'd0);
    chk("async_rst_end", 32'(period_end_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; presc_i = '0; period_i = 8'd9;
    wr_duty(0, 3); wr_duty(1, 5);
    wait_end(300, "post_rst_wrap");

    // ena low for 7 cycles: outputs frozen, shadow write still taken
    @(posedge clk); @(posedge clk); #1 ena = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      duty_wr_i = (i == 2); duty_ch_i = 3'd2; duty_i = 8'd4;
      @(negedge clk);
      chk("frz_pwm", 32'(pwm_o), 32'd3);
      chk("frz_end", 32'(period_end_o), 32'd0);
    end
    @(posedge clk); #1 ena = 1'b1; duty_wr_i = 1'b0;
    wait_end(20, "frz_resume");
    win(10, -1, 0, 0, hi, ends);
    chk("frz_wr_ch2", 32'(hi[2]), 32'd4); chk("frz_ch0", 32'(hi[0]), 32'd3);

    // randomized segments, scoreboard only
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1 rst_n = 1'b0; ena = 1'b0; duty_wr_i = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1; ena = 1'b1;
      presc_i = 16'($urandom_range(0, 2)); period_i = 8'($urandom_range(0, 12));
      for (int c = 0; c < 2000; c++) begin
        @(posedge clk); #1;
        ena       = ($urandom_range(0, 9) != 0);
        duty_wr_i = ($urandom_range(0, 3) == 0);
        duty_ch_i = 3'($urandom_range(0, 7));
        duty_i    = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 14));
        if ($urandom_range(0, 49) == 0) period_i = 8'($urandom_range(0, 12));
      end
    end
    @(posedge clk); #1 duty_wr_i = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
